cpu_control_sequencer: RTL and testbench

- Control FSM that sits directly upstream of the instructionset datapath and drives all of its load, select and mode inputs.
- Consumes the 4-bit opcode the datapath presents on IRCU.
- On Start, sequences operand load, ALU execute and result store, then reports Done.
- Replaces hand-driven Aload/Bload/ANSload/select strobes with a fixed, parameterised cycle schedule.

---
 rtl/cpu_control_sequencer_if.sv | 25 ++
 rtl/cpu_control_sequencer.sv | 128 ++++++++++++
 tb/tb_cpu_control_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_sequencer_if.sv
// Control bundle between the sequencer and its instruction-set datapath.
// The master drives Start/IRCU, and the sequencer (slave) drives the strobes and status.
interface cpu_control_sequencer_if;
    logic       Start;
    logic [3:0] IRCU;
    logic       Aload;
    logic       Bload;
    logic       ANSload;
    logic       A_select;
    logic       B_select;
    logic [1:0] select_mode;
    logic       Busy;
    logic       Done;
    logic       Halted;

    modport master (
        output Start, IRCU,
        input  Aload, Bload, ANSload, A_select, B_select, select_mode, Busy, Done, Halted
    );

    modport slave (
        input  Start, IRCU,
        output Aload, Bload, ANSload, A_select, B_select, select_mode, Busy, Done, Halted
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Fixed-schedule control FSM for the datapath: LOAD, EXEC, STORE, DONE. Done follows Start by LOAD+EXEC+2 cycles.
// All outputs are registered. Start is taken only in IDLE, and a Start that arrives while busy is dropped.
module cpu_control_sequencer #(
    parameter int LOAD_CYCLES = 1,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    cpu_control_sequencer_if.slave       bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EXEC  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);
    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t     state;
    logic [3:0] op;
    logic [3:0] cnt;
    logic       aload_r, bload_r, ansload_r, a_sel_r, b_sel_r;
    logic [1:0] mode_r;
    logic       busy_r, done_r, halted_r;

    // Each transition writes the outputs of the state being entered, so the output registers update together with the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            op        <= 4'h0;
            cnt       <= 4'h0;
            aload_r   <= 1'b0;
            bload_r   <= 1'b0;
            ansload_r <= 1'b0;
            a_sel_r   <= 1'b0;
            b_sel_r   <= 1'b0;
            mode_r    <= 2'b00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            aload_r   <= 1'b0;
            bload_r   <= 1'b0;
            ansload_r <= 1'b0;
            done_r    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        if (bus.IRCU == 4'hF) begin
                            state    <= HALT;
                            halted_r <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            op      <= bus.IRCU;
                            cnt     <= 4'h0;
                            aload_r <= 1'b1;
                            bload_r <= 1'b1;
                            a_sel_r <= bus.IRCU[2];
                            b_sel_r <= bus.IRCU[3];
                            mode_r  <= bus.IRCU[1:0];
                            busy_r  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    a_sel_r <= op[2];
                    b_sel_r <= op[3];
                    mode_r  <= op[1:0];
                    if (cnt == LOAD_LAST) begin
                        state <= EXEC;
                        cnt   <= 4'h0;
                    end else begin
                        cnt     <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
                        aload_r <= 1'b1;
                        bload_r <= 1'b1;
                    end
                end
                EXEC: begin
                    a_sel_r <= op[2];
                    b_sel_r <= op[3];
                    mode_r  <= op[1:0];
                    if (cnt == EXEC_LAST) begin
                        state     <= STORE;
                        ansload_r <= 1'b1;
                    end else begin
                        cnt <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
                    end
                end
                STORE: begin
                    state   <= DONE;
                    done_r  <= 1'b1;
                    a_sel_r <= 1'b0;
                    b_sel_r <= 1'b0;
                    mode_r  <= 2'b00;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                HALT: begin
                    state    <= HALT;
                    halted_r <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Aload       = aload_r;
    assign bus.Bload       = bload_r;
    assign bus.ANSload     = ansload_r;
    assign bus.A_select    = a_sel_r;
    assign bus.B_select    = b_sel_r;
    assign bus.select_mode = mode_r;
    assign bus.Busy        = busy_r;
    assign bus.Done        = done_r;
    assign bus.Halted      = halted_r;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for two sequencer configurations (1/1 and 3/2) that share the same stimulus.
// A schedule-based reference fills the expected outputs for each cycle, and a negedge monitor compares them.
module tb_cpu_control_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_control_sequencer_if bus0 ();
    cpu_control_sequencer_if bus1 ();

    cpu_control_sequencer #(.LOAD_CYCLES(1), .EXEC_CYCLES(1)) dut0 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus0.slave)
    );

    cpu_control_sequencer #(.LOAD_CYCLES(3), .EXEC_CYCLES(2)) dut1 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus1.slave)
    );

    int checks = 0;
    int failures = 0;
    int edge_k = 0;

    // Expected output vector: {Aload,Bload,ANSload,A_select,B_select,select_mode,Busy,Done,Halted}
    logic [9:0] sched [2][4096];
    bit         m_halted [2];
    int         m_free [2];
    logic [9:0] expq0 [$];
    logic [9:0] expq1 [$];

    function automatic logic [9:0] pack(input bit ld, input bit ans, input logic [3:0] op,
                                        input bit sel_on, input bit busy, input bit dn);
        logic [9:0] v;
        v = '0;
        v[9] = ld;
        v[8] = ld;
        v[7] = ans;
        if (sel_on) begin
            v[6]   = op[2];
            v[5]   = op[3];
            v[4:3] = op[1:0];
        end
        v[2] = busy;
        v[1] = dn;
        return v;
    endfunction

    // An accepted Start at edge k sets the outputs for the intervals that follow edges k..k+L+E+1.
    task automatic model_edge(input int d, input int L, input int E, input bit r, input bit st,
                              input logic [3:0] ir, output logic [9:0] e);
        int k;
        k = edge_k;
        if (r) begin
            for (int j = k; j < k + 32; j++) sched[d][j] = '0;
            m_halted[d] = 1'b0;
            m_free[d]   = k + 1;
        end else if (!m_halted[d] && st && k >= m_free[d]) begin
            if (ir == 4'hF) begin
                m_halted[d] = 1'b1;
            end else begin
                for (int j = 0; j < L; j++) sched[d][k + j] = pack(1'b1, 1'b0, ir, 1'b1, 1'b1, 1'b0);
                for (int j = 0; j < E; j++) sched[d][k + L + j] = pack(1'b0, 1'b0, ir, 1'b1, 1'b1, 1'b0);
                sched[d][k + L + E]     = pack(1'b0, 1'b1, ir, 1'b1, 1'b1, 1'b0);
                sched[d][k + L + E + 1] = pack(1'b0, 1'b0, ir, 1'b0, 1'b1, 1'b1);
                m_free[d] = k + L + E + 3;
            end
        end
        e = sched[d][k];
        e[0] = m_halted[d];
    endtask

    task automatic step(input bit r, input bit st, input logic [3:0] ir);
        logic [9:0] e0, e1;
        rst = r;
        bus0.Start = st;
        bus0.IRCU  = ir;
        bus1.Start = st;
        bus1.IRCU  = ir;
        @(posedge clk);
        model_edge(0, 1, 1, r, st, ir, e0);
        model_edge(1, 3, 2, r, st, ir, e1);
        expq0.push_back(e0);
        expq1.push_back(e1);
        edge_k++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
    endtask

    // Monitor: pops one expectation for each DUT on every negedge after an edge has been modelled.
    initial begin
        logic [9:0] got, exp_v;
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (expq0.size() > 0) begin
                exp_v = expq0.pop_front();
                got = {bus0.Aload, bus0.Bload, bus0.ANSload, bus0.A_select, bus0.B_select,
                       bus0.select_mode, bus0.Busy, bus0.Done, bus0.Halted};
                checks++;
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL outputs_cfg11 cyc=%0d got=%b expected=%b", cyc, got, exp_v);
                end
            end
            if (expq1.size() > 0) begin
                exp_v = expq1.pop_front();
                got = {bus1.Aload, bus1.Bload, bus1.ANSload, bus1.A_select, bus1.B_select,
                       bus1.select_mode, bus1.Busy, bus1.Done, bus1.Halted};
                checks++;
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL outputs_cfg32 cyc=%0d got=%b expected=%b", cyc, got, exp_v);
                end
            end
            cyc++;
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 4096; j++) sched[d][j] = '0;
            m_halted[d] = 1'b0;
            m_free[d]   = 0;
        end
        bus0.Start = 1'b0; bus0.IRCU = 4'h0;
        bus1.Start = 1'b0; bus1.IRCU = 4'h0;

        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);

        // Single instruction, op 6.
        step(1'b0, 1'b1, 4'b0110);
        idle(10);

        // Start re-pulsed while running.
        step(1'b0, 1'b1, 4'h1);
        step(1'b0, 1'b0, 4'h1);
        step(1'b0, 1'b1, 4'h2);
        step(1'b0, 1'b0, 4'h2);
        step(1'b0, 1'b1, 4'h3);
        idle(10);

        // Start held high continuously.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'h1);
        idle(10);

        // IRCU changes after Start.
        step(1'b0, 1'b1, 4'hA);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 4'h3);

        // Reset during EXEC, then a normal run.
        step(1'b0, 1'b1, 4'h5);
        step(1'b0, 1'b0, 4'h5);
        step(1'b1, 1'b0, 4'h5);
        idle(8);
        step(1'b0, 1'b1, 4'hC);
        idle(10);

        // HALT, ignored Starts, reset, then a run.
        step(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'h4);
        step(1'b1, 1'b1, 4'h4);
        step(1'b0, 1'b1, 4'h7);
        idle(10);

        // Randomized traffic.
        for (int i = 0; i < 1800; i++) begin
            bit r, st;
            logic [3:0] ir;
            r  = ($urandom_range(0, 99) < 3);
            st = ($urandom_range(0, 99) < 55);
            ir = 4'($urandom_range(0, 15));
            step(r, st, ir);
        end
        idle(10);

        for (int i = 0; i < 5 && (expq0.size() > 0 || expq1.size() > 0); i++) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (expq0.size() > 0 || expq1.size() > 0) begin
            failures++;
            $display("FAIL drain got=%0d/%0d pending expected=0", expq0.size(), expq1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
